rd_uart_ctrl: RTL and testbench
===============================

// Module: rd_uart_ctrl
// PURPOSE
//  Command/response controller wrapped around the rd restoring divider.
//  Pops two operand bytes (x, then y) from the UART RX FIFO, launches rd with a
//  one-cycle start pulse and waits for done. It then pushes quotient and remainder
//  into the UART TX FIFO. Handles divide-by-zero locally and recovers from a hung divider.
// PARAMETERS
//  W            8     operand/result width; equals the UART byte width
//  TIMEOUT_CYC  1023  max cycles spent in WAIT before aborting; >=1
// PORTS
//  clk        in   1  system clock; everything samples on rising edge
//  reset      in   1  asynchronous, active-high reset
//  rx_empty   in   1  RX FIFO empty; r_data valid when 0 (show-ahead FIFO)
//  r_data     in   W  RX FIFO head byte
//  rd_uart    out  1  RX pop strobe; one pop per clk cycle asserted
//  tx_full    in   1  TX FIFO full; writes dropped by FIFO when 1
//  w_data     out  W  TX FIFO write data
//  wr_uart    out  1  TX push strobe
//  x          out  W  dividend to rd
//  y          out  W  divisor to rd
//  start      out  1  rd launch pulse
//  done       in   1  rd completion pulse; quotient/remainder valid this cycle
//  quotient   in   W  from rd
//  remainder  in   W  from rd
//  busy       out  1  1 in every state except RD_X
//  err        out  1  one-cycle pulse on divide-by-zero or timeout
// BEHAVIOUR
//  States: RD_X -> RD_Y -> (START -> WAIT | ZERO) -> WR_Q -> WR_R -> RD_X.
//  Reset (async): state=RD_X; x,y,q_reg,r_reg=0; start=0; err=0; timer=0.
//   rd_uart=0 and wr_uart=0 while reset is high.
//  RD_X: if !rx_empty -> rd_uart=1, x<=r_data, go RD_Y; else hold, rd_uart=0.
//  RD_Y: if !rx_empty -> rd_uart=1, y<=r_data. Go ZERO if r_data==0, else START.
//  rd_uart is combinational: (state==RD_X||state==RD_Y) && !rx_empty && !reset.
//   Exactly one pop per operand. No pop while rx_empty=1.
//  START: start=1 for exactly this one cycle (registered; 0 in all other states).
//   Clear timer. Go WAIT.
//  WAIT: on done=1 -> q_reg<=quotient, r_reg<=remainder, go WR_Q.
//   Otherwise timer++. When timer reaches TIMEOUT_CYC-1 without done:
//   q_reg<=all-ones, r_reg<=all-ones, err=1 (1 cycle), go WR_Q.
//   done in the same cycle as the timeout edge: done wins, no err.
//  ZERO: divider is not started. q_reg<=all-ones, r_reg<=x, err=1 (1 cycle), go WR_Q.
//  done outside WAIT is ignored: no capture, no state change.
//  x and y stay stable from the RD_Y exit until the next RD_X capture.
//  WR_Q: w_data=q_reg. wr_uart=!tx_full. Advance to WR_R only on a cycle with tx_full=0.
//  WR_R: w_data=r_reg, same rule; then go RD_X.
//   w_data holds its value while stalled. No wr_uart while tx_full=1.
//  Latency: y popped at cycle N. start at N+1. Divider done at N+1+D.
//   Q pushed at N+2+D, R at N+3+D, assuming tx not full.
//  Reset mid-operation: abandon everything, return to RD_X.
//   A late done from rd after reset is ignored.
//  Throughput: one command per (D+5) cycles minimum, no pipelining of commands.
// TESTING
//  1. RX bytes 0x08,0x10 -> single start pulse; with rd done, TX gets 0x00 then 0x08.
//  2. RX 0xC8,0x07 -> TX 0x1C,0x04. Two back-to-back commands preloaded in FIFO.
//     -> TX 0x1C,0x04,0x1C,0x04; exactly 4 rd_uart pulses total.
//  3. RX 0x2A,0x00 -> start never asserts; err pulses once; TX 0xFF,0x2A.
//  4. tx_full=1 for 50 cycles at WR_Q -> wr_uart stays 0 and w_data is stable.
//     Release -> TX 0x00,0x08 in two consecutive cycles.
//  5. rx_empty gaps of 20 cycles between x and y -> no spurious pop.
//     Capture is correct; rd_uart asserts only when rx_empty=0.
//  6. Stub divider that never asserts done, TIMEOUT_CYC=16 -> err pulses once.
//     TX gets 0xFF,0xFF after 16 WAIT cycles. Then reset during WAIT of the next command.
//     -> busy=0, start=0, state RD_X; a later done is ignored and produces no TX write.

Source files
------------

// File: rtl/rd_uart_ctrl.sv
// Command/response controller: pops dividend and divisor bytes from the UART RX FIFO,
// runs the external rd divider (or short-circuits divide-by-zero / divider hang) and
// pushes quotient then remainder into the UART TX FIFO.
module rd_uart_ctrl #(
    parameter int W           = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_empty,
    input  logic [W-1:0] r_data,
    output logic         rd_uart,
    input  logic         tx_full,
    output logic [W-1:0] w_data,
    output logic         wr_uart,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         start,
    input  logic         done,
    input  logic [W-1:0] quotient,
    input  logic [W-1:0] remainder,
    output logic         busy,
    output logic         err
);

    // Timer counts 0..TIMEOUT_CYC-1 inside WAIT, so clog2(TIMEOUT_CYC) bits suffice.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_RD_X  = 3'd0,
        ST_RD_Y  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ZERO  = 3'd4,
        ST_WR_Q  = 3'd5,
        ST_WR_R  = 3'd6
    } state_e;

    state_e         state_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic [W-1:0]   q_q;
    logic [W-1:0]   r_q;
    logic           start_q;
    logic           err_q;
    logic [TW-1:0]  timer_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RD_X;
            x_q     <= '0;
            y_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            // NOTE: non-blocking throughout; the pulse defaults below are overridden
            // by a later assignment in the same cycle, which is how one-cycle pulses are made.
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_RD_X: begin
                    if (!rx_empty) begin
                        x_q     <= r_data;
                        state_q <= ST_RD_Y;
                    end
                end
                ST_RD_Y: begin
                    if (!rx_empty) begin
                        y_q <= r_data;
                        if (r_data == '0) begin
                            state_q <= ST_ZERO;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done on the timeout cycle takes priority over the abort
                    if (done) begin
                        q_q     <= quotient;
                        r_q     <= remainder;
                        state_q <= ST_WR_Q;
                    end else if (timer_q == TIMER_LAST) begin
                        q_q     <= '1;
                        r_q     <= '1;
                        err_q   <= 1'b1;
                        state_q <= ST_WR_Q;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_ZERO: begin
                    q_q     <= '1;
                    r_q     <= x_q;
                    err_q   <= 1'b1;
                    state_q <= ST_WR_Q;
                end
                ST_WR_Q: begin
                    if (!tx_full) state_q <= ST_WR_R;
                end
                ST_WR_R: begin
                    if (!tx_full) state_q <= ST_RD_X;
                end
                default: state_q <= ST_RD_X;
            endcase
        end
    end

    // FIFO strobes are combinational so a pop/push lands in the same cycle as the decision.
    assign rd_uart = ((state_q == ST_RD_X) || (state_q == ST_RD_Y)) && !rx_empty && !reset;
    assign wr_uart = ((state_q == ST_WR_Q) || (state_q == ST_WR_R)) && !tx_full && !reset;
    assign w_data  = (state_q == ST_WR_Q) ? q_q : r_q;

    assign x     = x_q;
    assign y     = y_q;
    assign start = start_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_RD_X);

endmodule

// File: tb/tb_rd_uart_ctrl.sv
// Self-checking bench for rd_uart_ctrl: RX/TX FIFO models, a stub divider with
// programmable latency, and a scoreboard of expected TX bytes.
module tb_rd_uart_ctrl;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx_empty;
    logic [W-1:0] r_data;
    logic         rd_uart;
    logic         tx_full;
    logic [W-1:0] w_data;
    logic         wr_uart;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         start;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         err;

    rd_uart_ctrl #(.W(W), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .x         (x),
        .y         (y),
        .start     (start),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] rx_q[$];
    logic [W-1:0] exp_q[$];
    int           wr_cyc[$];
    int           pops = 0;
    int           starts = 0;
    int           errs = 0;
    int           last_pop_cyc = 0;
    int           last_start_cyc = 0;
    bit           pop_pending = 0;
    int           div_cnt = 0;
    int           div_lat = 5;
    bit           stub_hang = 0;
    bit           force_done = 0;
    logic [W-1:0] sx;
    logic [W-1:0] sy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic rx_refresh();
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? '0 : rx_q[0];
    endtask

    // Monitor: samples DUT outputs mid-cycle and checks every TX push against the scoreboard.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            pop_pending = (rd_uart === 1'b1);
            if (rd_uart === 1'b1) begin
                pops++;
                last_pop_cyc = cyc;
                total++;
                if (rx_empty !== 1'b0 || reset !== 1'b0) begin
                    bad++;
                    $display("FAIL pop_gate: rd_uart=1 with rx_empty=%b reset=%b, required no pop", rx_empty, reset);
                end
            end
            if (wr_uart === 1'b1) begin
                wr_cyc.push_back(cyc);
                total++;
                if (tx_full !== 1'b0) begin
                    bad++;
                    $display("FAIL wr_gate: wr_uart=1 while tx_full=%b, required 0", tx_full);
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected: got w_data=%h, required no write", w_data);
                end else begin
                    e = exp_q.pop_front();
                    if (w_data !== e) begin
                        bad++;
                        $display("FAIL tx_data: got %h, required %h", w_data, e);
                    end
                end
            end
            if (start === 1'b1) begin
                starts++;
                last_start_cyc = cyc;
                sx = x;
                sy = y;
                if (!stub_hang) div_cnt = div_lat;
            end
            if (err === 1'b1) errs++;
        end
    end

    // Driver: RX FIFO pop and stub divider, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_pending) begin
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                pop_pending = 0;
            end
            rx_refresh();
            done = 1'b0;
            if (force_done) begin
                done       = 1'b1;
                quotient   = 8'h5A;
                remainder  = 8'hA5;
                force_done = 0;
            end else if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    done      = 1'b1;
                    quotient  = (sy != 0) ? sx / sy : '1;
                    remainder = (sy != 0) ? sx % sy : '1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #2;
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_refresh();
    endtask

    task automatic push_byte(input logic [W-1:0] a);
        @(posedge clk);
        #2;
        rx_q.push_back(a);
        rx_refresh();
    endtask

    task automatic set_tx_full(input logic v);
        @(posedge clk);
        #2;
        tx_full = v;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s_idle: %0d bytes still pending busy=%b after %0d cycles, required 0", tag, exp_q.size(), busy, budget);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rx_q.push_back(8'h33);
        rx_refresh();
        tick();
        tick();
        total++;
        if ({rd_uart, wr_uart, busy, start, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: rd,wr,busy,start,err=%b, required 00000", {rd_uart, wr_uart, busy, start, err});
        end
        total++;
        if (x !== 8'h00 || y !== 8'h00) begin
            bad++;
            $display("FAIL reset_ops: x=%h y=%h, required 00 00", x, y);
        end
        rx_q.delete();
        rx_refresh();
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int p0 = pops;
        int s0 = starts;
        int e0 = errs;
        int w0 = wr_cyc.size();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        push_cmd(8'h08, 8'h10);
        wait_idle(200, "basic");
        total++;
        if (starts - s0 != 1 || errs - e0 != 0 || pops - p0 != 2) begin
            bad++;
            $display("FAIL basic_counts: starts=%0d errs=%0d pops=%0d, required 1 0 2", starts - s0, errs - e0, pops - p0);
        end
        total++;
        if (last_start_cyc != last_pop_cyc + 1) begin
            bad++;
            $display("FAIL basic_start_lat: start at %0d, required %0d", last_start_cyc, last_pop_cyc + 1);
        end
        total++;
        if (wr_cyc.size() < w0 + 2) begin
            bad++;
            $display("FAIL basic_wr_lat: %0d writes, required 2", wr_cyc.size() - w0);
        end else if (wr_cyc[w0] != last_pop_cyc + 2 + div_lat || wr_cyc[w0+1] != last_pop_cyc + 3 + div_lat) begin
            bad++;
            $display("FAIL basic_wr_lat: writes at %0d,%0d, required %0d,%0d", wr_cyc[w0], wr_cyc[w0+1],
                     last_pop_cyc + 2 + div_lat, last_pop_cyc + 3 + div_lat);
        end
    endtask

    task automatic test_back_to_back();
        int p0 = pops;
        int s0 = starts;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h1C);
            exp_q.push_back(8'h04);
        end
        @(posedge clk);
        #2;
        rx_q.push_back(8'hC8);
        rx_q.push_back(8'h07);
        rx_q.push_back(8'hC8);
        rx_q.push_back(8'h07);
        rx_refresh();
        wait_idle(400, "b2b");
        total++;
        if (pops - p0 != 4 || starts - s0 != 2) begin
            bad++;
            $display("FAIL b2b_counts: pops=%0d starts=%0d, required 4 2", pops - p0, starts - s0);
        end
    endtask

    task automatic test_div_zero();
        int s0 = starts;
        int e0 = errs;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h2A);
        push_cmd(8'h2A, 8'h00);
        wait_idle(200, "zero");
        total++;
        if (starts - s0 != 0 || errs - e0 != 1) begin
            bad++;
            $display("FAIL zero_counts: starts=%0d errs=%0d, required 0 1", starts - s0, errs - e0);
        end
    endtask

    task automatic test_tx_stall();
        int n = 0;
        int w0;
        bit stall_ok = 1;
        set_tx_full(1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        push_cmd(8'h08, 8'h10);
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL stall_done: done not seen in %0d cycles, required a done pulse", n);
        end
        w0 = wr_cyc.size();
        tick();
        for (int i = 0; i < 50; i++) begin
            if (wr_uart !== 1'b0 || w_data !== 8'h00) stall_ok = 0;
            tick();
        end
        total++;
        if (!stall_ok || wr_cyc.size() != w0) begin
            bad++;
            $display("FAIL stall_hold: writes=%0d last w_data=%h, required 0 writes with w_data 00", wr_cyc.size() - w0, w_data);
        end
        set_tx_full(1'b0);
        wait_idle(50, "stall");
        total++;
        if (wr_cyc.size() != w0 + 2) begin
            bad++;
            $display("FAIL stall_release: %0d writes, required 2", wr_cyc.size() - w0);
        end else if (wr_cyc[w0+1] != wr_cyc[w0] + 1) begin
            bad++;
            $display("FAIL stall_release: writes at %0d,%0d, required consecutive", wr_cyc[w0], wr_cyc[w0+1]);
        end
    endtask

    task automatic test_rx_gaps();
        int p0 = pops;
        int s0 = starts;
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'h04);
        push_byte(8'hC8);
        repeat (20) tick();
        total++;
        if (pops - p0 != 1 || busy !== 1'b1 || starts != s0) begin
            bad++;
            $display("FAIL gap_wait: pops=%0d busy=%b starts=%0d, required 1 1 0", pops - p0, busy, starts - s0);
        end
        push_byte(8'h07);
        wait_idle(200, "gap");
        total++;
        if (pops - p0 != 2 || x !== 8'hC8 || y !== 8'h07) begin
            bad++;
            $display("FAIL gap_capture: pops=%0d x=%h y=%h, required 2 c8 07", pops - p0, x, y);
        end
    endtask

    task automatic test_timeout_edge();
        int e0 = errs;
        div_lat = TO;
        exp_q.push_back(8'h14);
        exp_q.push_back(8'h00);
        push_cmd(8'h64, 8'h05);
        wait_idle(200, "edge");
        total++;
        if (errs - e0 != 0) begin
            bad++;
            $display("FAIL edge_err: err pulses=%0d, required 0", errs - e0);
        end
        div_lat = 5;
    endtask

    task automatic test_timeout();
        int e0 = errs;
        int w0 = wr_cyc.size();
        int s0;
        int n = 0;
        stub_hang = 1;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        push_cmd(8'h64, 8'h05);
        wait_idle(200, "timeout");
        total++;
        if (errs - e0 != 1) begin
            bad++;
            $display("FAIL timeout_err: err pulses=%0d, required 1", errs - e0);
        end
        total++;
        if (wr_cyc.size() <= w0) begin
            bad++;
            $display("FAIL timeout_lat: no write, required write at %0d", last_start_cyc + TO + 1);
        end else if (wr_cyc[w0] != last_start_cyc + TO + 1) begin
            bad++;
            $display("FAIL timeout_lat: write at %0d, required %0d", wr_cyc[w0], last_start_cyc + TO + 1);
        end

        s0 = starts;
        w0 = wr_cyc.size();
        push_cmd(8'h10, 8'h02);
        while (starts == s0 && n < 50) begin
            tick();
            n++;
        end
        repeat (5) tick();
        @(posedge clk);
        #2;
        reset   = 1'b1;
        div_cnt = 0;
        tick();
        total++;
        if (busy !== 1'b0 || start !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL midreset: busy=%b start=%b err=%b, required 0 0 0", busy, start, err);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick();
        force_done = 1;
        repeat (20) tick();
        total++;
        if (wr_cyc.size() != w0 || busy !== 1'b0 || starts != s0 + 1) begin
            bad++;
            $display("FAIL late_done: writes=%0d busy=%b starts=%0d, required 0 0 1", wr_cyc.size() - w0, busy, starts - s0);
        end
        stub_hang = 0;
    endtask

    initial begin
        reset     = 1'b1;
        tx_full   = 1'b0;
        done      = 1'b0;
        quotient  = '0;
        remainder = '0;
        rx_refresh();
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_tx_stall();
        test_rx_gaps();
        test_timeout_edge();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
